// File: rtl/color_pkg.sv
// rtl/color_pkg.sv - filter select codes, color codes and scan states shared by the color scanner
package color_pkg;

    // Slot index equals the filter select code, so slot order is red, blue, clear, green
    localparam logic [1:0] SEL_RED   = 2'b00;
    localparam logic [1:0] SEL_BLUE  = 2'b01;
    localparam logic [1:0] SEL_CLEAR = 2'b10;
    localparam logic [1:0] SEL_GREEN = 2'b11;

    localparam logic [1:0] COL_NONE  = 2'b00;
    localparam logic [1:0] COL_RED   = 2'b01;
    localparam logic [1:0] COL_GREEN = 2'b10;
    localparam logic [1:0] COL_BLUE  = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_GATE,
        ST_STORE,
        ST_CLASSIFY
    } state_e;

endpackage

// File: rtl/edge_counter.sv
// rtl/edge_counter.sv - synchronizes one sensor wave and counts its rising edges with saturation
module edge_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             wave_i,
    input  logic             clr_i,
    input  logic             en_i,
    output logic [CNT_W-1:0] count_o
);

    // [0],[1] form the synchronizer; [2] holds the previous synchronized value
    logic [2:0]       sync_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             rise;

    assign rise    = sync_q[1] & ~sync_q[2];
    assign count_o = cnt_q;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i && rise && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q <= '0;
            cnt_q  <= '0;
        end else begin
            sync_q <= {sync_q[1:0], wave_i};
            cnt_q  <= cnt_d;
        end
    end

endmodule

// File: rtl/color_scan.sv
// rtl/color_scan.sv - steps the shared filter through red/blue/clear/green and classifies each channel
module color_scan import color_pkg::*; #(
    parameter int CH        = 2,
    parameter int CLK_DIV   = 50,
    parameter int SETTLE_US = 100,
    parameter int GATE_US   = 1000,
    parameter int CNT_W     = 16,
    parameter int MIN_CLEAR = 20
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            en,
    input  logic [CH-1:0]   wave,
    output logic [1:0]      sel,
    output logic [2*CH-1:0] color,
    output logic            valid
);

    localparam int DIV_W   = $clog2(CLK_DIV + 1);
    localparam int TMAX    = (SETTLE_US > GATE_US) ? SETTLE_US : GATE_US;
    localparam int TCK_W   = $clog2(TMAX + 1);
    localparam logic [DIV_W-1:0] DIV_LAST    = DIV_W'(CLK_DIV - 1);
    localparam logic [TCK_W-1:0] SETTLE_LAST = TCK_W'(SETTLE_US - 1);
    localparam logic [TCK_W-1:0] GATE_LAST   = TCK_W'(GATE_US - 1);

    state_e            state_q, state_d;
    logic [DIV_W-1:0]  div_q, div_d;
    logic [TCK_W-1:0]  tck_q, tck_d;
    logic [1:0]        idx_q, idx_d;
    logic [2*CH-1:0]   color_q, color_d;
    logic              valid_q, valid_d;
    logic [CNT_W-1:0]  slot_q [CH][4];
    logic [CNT_W-1:0]  count [CH];
    logic [2*CH-1:0]   class_w;
    logic              tick, cnt_clr, cnt_en;

    function automatic logic [1:0] classify(input logic [CNT_W-1:0] r, g, b, c);
        if (c < CNT_W'(MIN_CLEAR)) return COL_NONE;
        if ((r >= g) && (r >= b))  return COL_RED;
        if (g >= b)                return COL_GREEN;
        return COL_BLUE;
    endfunction

    for (genvar gi = 0; gi < CH; gi++) begin : g_ch
        edge_counter #(.CNT_W(CNT_W)) u_cnt (
            .clk_i   (clk),
            .rst_ni  (rst),
            .wave_i  (wave[gi]),
            .clr_i   (cnt_clr),
            .en_i    (cnt_en),
            .count_o (count[gi])
        );
    end

    assign tick   = (div_q == DIV_LAST);
    assign cnt_en = (state_q == ST_GATE);
    assign sel    = (state_q == ST_IDLE) ? SEL_RED : idx_q;
    assign color  = color_q;
    assign valid  = valid_q;

    always_comb begin
        class_w = '0;
        for (int c = 0; c < CH; c++) begin
            class_w[2*c +: 2] = classify(slot_q[c][SEL_RED], slot_q[c][SEL_GREEN],
                                         slot_q[c][SEL_BLUE], slot_q[c][SEL_CLEAR]);
        end
    end

    always_comb begin
        state_d = state_q;
        tck_d   = tck_q;
        idx_d   = idx_q;
        cnt_clr = 1'b0;
        div_d   = tick ? '0 : div_q + 1'b1;
        valid_d = (state_q == ST_CLASSIFY);
        color_d = (state_q == ST_CLASSIFY) ? class_w : color_q;
        case (state_q)
            ST_IDLE: begin
                div_d   = '0;
                tck_d   = '0;
                idx_d   = '0;
                cnt_clr = 1'b1;
                if (en) state_d = ST_SETTLE;
            end
            ST_SETTLE: if (tick) begin
                if (tck_q == SETTLE_LAST) begin
                    tck_d   = '0;
                    cnt_clr = 1'b1;
                    state_d = ST_GATE;
                end else begin
                    tck_d = tck_q + 1'b1;
                end
            end
            ST_GATE: if (tick) begin
                if (tck_q == GATE_LAST) begin
                    tck_d   = '0;
                    state_d = ST_STORE;
                end else begin
                    tck_d = tck_q + 1'b1;
                end
            end
            ST_STORE: begin
                if (idx_q == 2'd3) begin
                    state_d = ST_CLASSIFY;
                end else begin
                    idx_d   = idx_q + 1'b1;
                    state_d = ST_SETTLE;
                end
            end
            ST_CLASSIFY: begin
                idx_d   = '0;
                state_d = en ? ST_SETTLE : ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        // CLASSIFY is a single clk that always finishes; every other active state aborts on en low
        if (!en && (state_q != ST_IDLE) && (state_q != ST_CLASSIFY)) state_d = ST_IDLE;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            div_q   <= '0;
            tck_q   <= '0;
            idx_q   <= '0;
            color_q <= '0;
            valid_q <= 1'b0;
            for (int c = 0; c < CH; c++) begin
                for (int f = 0; f < 4; f++) slot_q[c][f] <= '0;
            end
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            tck_q   <= tck_d;
            idx_q   <= idx_d;
            color_q <= color_d;
            valid_q <= valid_d;
            if (state_q == ST_STORE) begin
                for (int c = 0; c < CH; c++) slot_q[c][idx_q] <= count[c];
            end
        end
    end

endmodule

// File: tb/tb_color_scan.sv
// tb/tb_color_scan.sv - directed scans against per-filter sensor models with an expected-color scoreboard
module tb_color_scan;

    localparam int CH        = 2;
    localparam int CLK_DIV   = 4;
    localparam int SETTLE_US = 4;
    localparam int GATE_US   = 200;
    localparam int CNT_W     = 8;
    localparam int MIN_CLEAR = 20;
    localparam int PHASE_CLKS = (SETTLE_US + GATE_US) * CLK_DIV;
    localparam int SCAN_CLKS  = 4 * PHASE_CLKS;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            en  = 1'b0;
    logic [CH-1:0]   wave = '0;
    logic [1:0]      sel;
    logic [2*CH-1:0] color;
    logic            valid;

    color_scan #(
        .CH(CH), .CLK_DIV(CLK_DIV), .SETTLE_US(SETTLE_US), .GATE_US(GATE_US),
        .CNT_W(CNT_W), .MIN_CLEAR(MIN_CLEAR)
    ) dut (
        .clk(clk), .rst(rst), .en(en), .wave(wave),
        .sel(sel), .color(color), .valid(valid)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;
    logic [2*CH-1:0] exp_q [$];

    always @(posedge clk) cyc <= cyc + 1;

    // Sensor model: half-period in clks per channel per filter (index = sel); restarts low on every filter change
    int half_per [CH][4];
    int wcnt [CH];
    logic [1:0] last_sel = 2'b00;

    always @(negedge clk) begin
        for (int c = 0; c < CH; c++) begin
            if (sel !== last_sel) begin
                wcnt[c] = 0;
                wave[c] = 1'b0;
            end else begin
                wcnt[c] = wcnt[c] + 1;
                if (wcnt[c] >= half_per[c][sel]) begin
                    wave[c] = ~wave[c];
                    wcnt[c] = 0;
                end
            end
        end
        last_sel = sel;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    task automatic set_profile(input int r0, b0, c0, g0, r1, b1, c1, g1);
        half_per[0][0] = r0; half_per[0][1] = b0; half_per[0][2] = c0; half_per[0][3] = g0;
        half_per[1][0] = r1; half_per[1][1] = b1; half_per[1][2] = c1; half_per[1][3] = g1;
    endtask

    task automatic clk_step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_valid(input string tag, output int at_cyc);
        int k;
        k = 0;
        at_cyc = -1;
        while (k < SCAN_CLKS + 200) begin
            clk_step();
            k++;
            if (valid === 1'b1) begin
                at_cyc = cyc;
                break;
            end
        end
        check({tag, "_valid_seen"}, valid, 1);
        if (valid === 1'b1) begin
            check({tag, "_sb_nonempty"}, exp_q.size() > 0, 1);
            if (exp_q.size() > 0) check({tag, "_color"}, color, exp_q.pop_front());
        end
    endtask

    task automatic wait_sel(input logic [1:0] target);
        int k;
        k = 0;
        while ((sel !== target) && (k < SCAN_CLKS)) begin
            clk_step();
            k++;
        end
    endtask

    task automatic one_scan(input string tag);
        int at;
        en = 1'b1;
        wait_valid(tag, at);
        clk_step();
        check({tag, "_valid_width"}, valid, 0);
        en = 1'b0;
        repeat (3) clk_step();
    endtask

    initial begin
        int c0, at, a0, a1, a2, n;
        bit saw_valid, saw_sel;
        set_profile(40, 40, 40, 40, 40, 40, 40, 40);

        #1 rst = 1'b0;
        #1;
        check("reset_sel", sel, 0);
        check("reset_color", color, 0);
        check("reset_valid", valid, 0);
        repeat (3) @(negedge clk);
        rst = 1'b1;

        // en low after reset: no scan may start
        saw_valid = 0; saw_sel = 0;
        repeat (40) begin
            clk_step();
            if (valid !== 1'b0) saw_valid = 1;
            if (sel !== 2'b00) saw_sel = 1;
        end
        check("idle_no_valid", saw_valid, 0);
        check("idle_sel", saw_sel, 0);

        // A: ch0 R200 B50 C255(sat) G50 -> red; ch1 all 10 -> clear below minimum
        set_profile(2, 8, 1, 8, 40, 40, 40, 40);
        exp_q.push_back(4'b0001);
        c0 = cyc;
        en = 1'b1;
        wait_valid("scanA", at);
        check("scanA_latency", ((at - c0) >= SCAN_CLKS) && ((at - c0) <= SCAN_CLKS + 16), 1);
        clk_step();
        check("scanA_valid_width", valid, 0);
        en = 1'b0;
        repeat (3) clk_step();

        // B: ch0 R20 B100 G100 -> green/blue tie resolves green
        set_profile(20, 4, 2, 4, 40, 40, 40, 40);
        exp_q.push_back(4'b0010);
        one_scan("scanB");

        // C: ch0 B 400 edges saturates to 255 (a wrap would give 144 < R200) -> blue; ch1 R=G tie -> red
        set_profile(2, 1, 4, 8, 5, 8, 2, 5);
        exp_q.push_back(4'b0111);
        one_scan("scanC");

        // D: ch0 green; ch1 clear exactly at the minimum still classifies -> red
        set_profile(40, 20, 5, 10, 16, 20, 20, 20);
        exp_q.push_back(4'b0110);
        one_scan("scanD");

        // Abort during the clear-filter gate
        set_profile(2, 8, 1, 8, 40, 40, 40, 40);
        en = 1'b1;
        wait_sel(2'b10);
        check("abort_reach_clear", sel, 2);
        repeat (40) clk_step();
        en = 1'b0;
        clk_step();
        check("abort_sel_idle", sel, 0);
        saw_valid = 0; saw_sel = 0;
        repeat (SCAN_CLKS + 50) begin
            clk_step();
            if (valid !== 1'b0) saw_valid = 1;
            if (sel !== 2'b00) saw_sel = 1;
        end
        check("abort_no_valid", saw_valid, 0);
        check("abort_sel_held", saw_sel, 0);
        check("abort_color_held", color, 4'b0110);

        // Restart begins with red: sel leaves 00 only after one settle+gate phase plus the store clk
        exp_q.push_back(4'b0001);
        en = 1'b1;
        n = 0;
        while ((sel !== 2'b01) && (n < 2 * PHASE_CLKS)) begin
            clk_step();
            n++;
        end
        check("restart_red_phase_len", n, PHASE_CLKS + 2);
        wait_valid("restart", at);
        en = 1'b0;
        repeat (3) clk_step();

        // Asynchronous reset in the middle of a gate
        set_profile(20, 4, 2, 4, 40, 40, 40, 40);
        en = 1'b1;
        wait_sel(2'b01);
        repeat (40) clk_step();
        #2 rst = 1'b0;
        #1;
        check("midrst_sel", sel, 0);
        check("midrst_color", color, 0);
        check("midrst_valid", valid, 0);
        @(negedge clk);
        rst = 1'b1;
        exp_q.push_back(4'b0010);
        wait_valid("postrst", at);
        en = 1'b0;
        repeat (3) clk_step();

        // Three back-to-back scans
        set_profile(2, 1, 4, 8, 5, 8, 2, 5);
        repeat (3) exp_q.push_back(4'b0111);
        en = 1'b1;
        wait_valid("cont0", a0);
        clk_step();
        check("cont0_width", valid, 0);
        wait_valid("cont1", a1);
        clk_step();
        check("cont1_width", valid, 0);
        wait_valid("cont2", a2);
        clk_step();
        check("cont2_width", valid, 0);
        check("cont_spacing01", a1 - a0, SCAN_CLKS);
        check("cont_spacing12", a2 - a1, SCAN_CLKS);
        en = 1'b0;
        repeat (3) clk_step();
        check("sb_drained", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/color_scan.md
COLOR_SCAN -- requirements
Module: color_scan

Interface
REQ-001 Parameter CH, default 2, number of color-sensor channels scanned in lockstep.
REQ-002 Parameter CLK_DIV, default 50, clk cycles per internal 1 us tick.
REQ-003 Parameter SETTLE_US, default 100, ticks waited after each filter change before counting starts.
REQ-004 Parameter GATE_US, default 1000, ticks per counting window.
REQ-005 Parameter CNT_W, default 16, edge-counter width.
REQ-006 Parameter MIN_CLEAR, default 20, minimum clear-filter count for a valid color.
REQ-007 clk  input  1  single system clock; all logic runs on this clock.
REQ-008 rst  input  1  asynchronous, active-low reset.
REQ-009 en  input  1  scan enable; high runs continuous scans, low holds idle.
REQ-010 wave  input  CH  asynchronous square waves from the sensors, one bit per channel.
REQ-011 sel  output  2  filter select {S2,S3}, shared by all sensors: 00 red, 01 blue, 10 clear, 11 green.
REQ-012 color  output  2*CH  per-channel result in bits [2i+1:2i]: 00 none, 01 red, 10 green, 11 blue.
REQ-013 valid  output  1  one-clk pulse when all color fields have been updated from a completed scan.

Function
REQ-014 Each wave bit SHALL pass a 2-flop synchronizer; a rising edge is a 0->1 transition of the synchronized bit.
REQ-015 A tick strobe SHALL fire once every CLK_DIV clk cycles; the prescaler free-runs and restarts from 0 when leaving IDLE.
REQ-016 States: IDLE, SETTLE, GATE, STORE, CLASSIFY.
REQ-017 IDLE: sel=00, counters cleared; en=1 -> SETTLE with filter index 0 (red).
REQ-018 SETTLE: sel drives the current filter; after SETTLE_US ticks -> GATE, with all counters cleared on entry.
REQ-019 GATE: each channel counts rising edges; after GATE_US ticks -> STORE.
REQ-020 STORE (1 clk): latch each channel's count into its slot for the current filter; index<3 -> increment index, go to SETTLE; index=3 -> CLASSIFY.
REQ-021 Filter order: red, blue, clear, green (sel 00, 01, 10, 11).
REQ-022 CLASSIFY (1 clk): update every color field, pulse valid, then go to SETTLE with index 0 if en=1, else IDLE.
REQ-023 Classification per channel: clear<MIN_CLEAR -> 00; otherwise the largest of R, G, B.
REQ-024 Classification ties SHALL resolve with priority red > green > blue.
REQ-025 Counters SHALL saturate at 2^CNT_W-1 and never wrap.
REQ-026 An edge coincident with the GATE exit clk SHALL be counted; edges outside GATE SHALL be ignored.
REQ-027 en low in any non-IDLE state -> IDLE on the next clk: partial counts discarded, color held, no valid pulse, sel=00.
REQ-028 valid SHALL never be high for two consecutive clks.
REQ-029 color SHALL change only in CLASSIFY.

Reset
REQ-030 While rst=0: state IDLE, sel=00, color all 0, valid=0, counters, slots and prescaler cleared.
REQ-031 The first scan after rst release SHALL begin only on a clk with en=1.

Structure
REQ-032 Shared package color_pkg: filter select constants, color code constants, state enumeration.
REQ-033 Sub-module edge_counter (synchronizer, edge detect, saturating counter, clear/enable inputs), instantiated CH times.
REQ-034 The FSM, tick prescaler, result slots and classifier SHALL reside in color_scan.

Verification
REQ-035 Defaults, ch0 sensor model R=200 kHz, G=50 kHz, B=50 kHz, clear=300 kHz, en held high -> color[1:0]=01 and one valid pulse within 4*1100*50+16 clk of en rising.
REQ-036 ch1 all filters 10 kHz (clear count 10<20) -> color[3:2]=00; same scan with ch0 G=B=150 kHz, R=20 kHz -> color[1:0]=10 (tie resolved to green).
REQ-037 CNT_W=8, ch0 B=1 MHz, R=100 kHz -> B slot saturates at 255 with no wrap; color[1:0]=11.
REQ-038 en dropped during GATE of the clear filter -> IDLE and sel=00 on the next clk, no valid pulse, color unchanged; en reasserted -> fresh scan starting with red.
REQ-039 rst asserted mid-GATE -> sel=00, color=0, valid=0 immediately, without waiting for a clk edge; after release with en=1, a full scan completes normally.
REQ-040 Continuous run of 3 scans -> valid pulses exactly 4*(SETTLE_US+GATE_US)*CLK_DIV + constant clk apart, each 1 clk wide.
